// File: rtl/dcache_controller_pkg.sv
// Shared geometry constants, FSM encoding and address-split helpers for the
// direct-mapped write-back data cache.
package dcache_controller_pkg;

    localparam int NUM_LINES  = 32;
    localparam int LINE_BITS  = 256;
    localparam int ADDR_W     = 32;
    localparam int TAG_W      = 22;
    localparam int IDX_W      = 5;
    localparam int OFF_W      = 5;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITEBACK   = 2'd1,
        REFILL      = 2'd2,
        REFILL_DONE = 2'd3
    } dcache_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:IDX_W+OFF_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W+OFF_W-1:OFF_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:2];
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the data cache; master is the
// cache controller, slave is the surrounding pipeline plus Data_Memory.
interface dcache_controller_if;

    logic [dcache_controller_pkg::ADDR_W-1:0]    p1_addr_i;
    logic [31:0]                                 p1_data_i;
    logic                                        p1_MemRead_i;
    logic                                        p1_MemWrite_i;
    logic [31:0]                                 p1_data_o;
    logic                                        p1_stall_o;

    logic [dcache_controller_pkg::ADDR_W-1:0]    mem_addr_o;
    logic [dcache_controller_pkg::LINE_BITS-1:0] mem_data_o;
    logic                                        mem_enable_o;
    logic                                        mem_write_o;
    logic [dcache_controller_pkg::LINE_BITS-1:0] mem_data_i;
    logic                                        mem_ack_i;

    modport master (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport slave (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: combinational read,
// synchronous full-line or single-word write, async clear of valid/dirty.
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_BITS-1:0]  line_data,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [31:0]           word_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    // A refill leaves the line clean; a store into a resident line dirties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= line_tag;
            data_mem[idx] <= line_data;
        end else if (word_we) begin
            data_mem[idx][{word_sel, 5'd0} +: 32] <= word_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic,
// miss FSM (write-back, refill, bubble) and the registered memory request.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_controller_if.master bus
);

    dcache_state_e         state;
    dcache_state_e         state_next;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  req;
    logic                  is_write;
    logic                  hit;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  line_we;
    logic                  word_we;

    logic [ADDR_W-1:0]     mem_addr_q;
    logic [LINE_BITS-1:0]  mem_data_q;
    logic                  mem_enable_q;
    logic                  mem_write_q;
    logic                  addr_lsb_unused;

    assign req_tag         = addr_tag(bus.p1_addr_i);
    assign req_idx         = addr_idx(bus.p1_addr_i);
    assign req_word        = addr_word(bus.p1_addr_i);
    assign addr_lsb_unused = ^bus.p1_addr_i[1:0];

    // A simultaneous read and write request is handled as a store.
    assign req      = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign is_write = bus.p1_MemWrite_i;
    assign hit      = req & rd_valid & (rd_tag == req_tag);

    dcache_sram u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (req_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .line_we   (line_we),
        .line_tag  (req_tag),
        .line_data (bus.mem_data_i),
        .word_we   (word_we),
        .word_sel  (req_word),
        .word_data (bus.p1_data_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Acks arriving in IDLE or REFILL_DONE fall through the default hold.
    always_comb begin
        state_next = state;
        line_we    = 1'b0;
        word_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_next = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                end else if (hit && is_write) begin
                    word_we = 1'b1;
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack_i) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_ack_i) begin
                    line_we    = 1'b1;
                    state_next = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The request is registered from the state being entered, so it is
    // stable from the first cycle of WRITEBACK/REFILL until the ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_next)
                WRITEBACK: begin
                    mem_enable_q <= 1'b1;
                    mem_write_q  <= 1'b1;
                    mem_addr_q   <= {rd_tag, req_idx, {OFF_W{1'b0}}};
                    mem_data_q   <= rd_line;
                end
                REFILL: begin
                    mem_enable_q <= 1'b1;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= {req_tag, req_idx, {OFF_W{1'b0}}};
                end
                default: begin
                    mem_enable_q <= 1'b0;
                    mem_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p1_stall_o   = (req & ~hit) | (state != IDLE);
    assign bus.p1_data_o    = rd_line[{req_word, 5'd0} +: 32];
    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the off-chip Data_Memory.
- Sits downstream of the EX_MEM pipeline register and replaces the direct Data_Memory hookup.
- On a miss it raises a stall that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB, then refills from memory with a req/ack handshake.

Parameters:
- NUM_LINES, 32, number of cache lines; index width is log2(NUM_LINES)=5.
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width is 5.
- ADDR_W, 32, byte address width; tag width is ADDR_W-10=22.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- p1_addr_i  in  32  CPU byte address (EX_MEM ALUout); bits[1:0] ignored.
- p1_data_i  in  32  CPU store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data, valid when p1_stall_o=0.
- p1_stall_o  out  1  pipeline freeze.
- mem_addr_o  out  32  line-aligned memory address; bits[4:0] are 0.
- mem_data_o  out  256  write-back line.
- mem_enable_o  out  1  memory request, held until ack.
- mem_write_o  out  1  1=write-back, 0=refill read.
- mem_data_i  in  256  refill line, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: tag=addr[31:10], index=addr[9:5], word=addr[4:2].
- Per-line storage: valid, dirty, 22-bit tag, 256-bit data.
- Request: req = MemRead|MemWrite. If both are asserted, treat the access as a write.
- Hit: req & valid[index] & tag match.
  - Combinational; zero-latency; p1_stall_o=0.
  - p1_data_o = selected word, in the same cycle.
- Write hit: on the clock edge, update the word and set dirty=1. The other 7 words are unchanged.
- Miss: req & !hit, in state IDLE.
  - p1_stall_o=1 combinationally in the same cycle.
  - The CPU holds p1_* stable while stalled.
- p1_stall_o = req & !hit, or state != IDLE. It is 0 whenever req=0.
- FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE: on a miss with victim valid&dirty, go to WRITEBACK. On any other miss, go to REFILL.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}, mem_data_o=victim line. On mem_ack_i go to REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,index,5'b0}. On mem_ack_i write mem_data_i into the line with valid=1, dirty=0, tag=req tag, then go to REFILL_DONE.
  - REFILL_DONE: one bubble cycle with stall=1, then go to IDLE. The access then hits; a write hit sets dirty.
- Memory outputs are registered from state, so enable, write and address are stable from the first cycle of each state until ack.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- Miss latency (clean victim) = memory latency + 2 cycles; with a dirty victim, add the write-back latency.
- Reset (asynchronous, active-high):
  - all valid=0, dirty=0, state=IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p1_stall_o follows the combinational rule.
  - Tag/data arrays need not be cleared.
- Reset mid-transaction: the FSM returns to IDLE at once and the pending memory request is dropped. A late ack is ignored.
- Index wrap: addresses differing only in tag map to the same line. Each conflict evicts the line; a dirty victim writes back first.

Decomposition:
- Shared package constants: TAG_W=22, IDX_W=5, OFF_W=5, WORD_SEL_W=3.
- Shared package: FSM state encoding (IDLE=2'd0, WRITEBACK=2'd1, REFILL=2'd2, REFILL_DONE=2'd3).
- Sub-module dcache_sram: tag/valid/dirty/data arrays.
  - Combinational read port.
  - Synchronous write port with full-line write and single-word write mask.
  - Asynchronous clear of valid/dirty.
- The controller holds the FSM, hit logic and memory interface.

Test Plan:
- Cold read 0x0000_0040 with memory returning a line whose word0=0x1111_1111 after 10 cycles:
  - stall rises the same cycle; WRITEBACK is skipped; mem_addr_o=0x40, mem_write_o=0.
  - after ack plus 1 cycle, stall=0 and p1_data_o=0x1111_1111.
- Write hit: after the refill above, store 0xDEAD_BEEF to 0x44.
  - no stall; a subsequent read of 0x44 returns 0xDEAD_BEEF; the line is dirty.
- Dirty eviction: read 0x0000_0440 (same index 2, tag 1).
  - WRITEBACK first, with mem_addr_o=0x40, mem_write_o=1 and mem_data_o word1=0xDEAD_BEEF.
  - then REFILL with mem_addr_o=0x440.
- Clean conflict: read 0x40, then 0x440, with no stores in between. No write-back request is issued.
- Reset asserted during REFILL:
  - mem_enable_o falls asynchronously and state=IDLE.
  - a re-read of 0x40 misses again because valid was cleared.
- Idle: req=0 with random mem_ack_i pulses. No state change, and stall stays 0.
